// File: rtl/nmix_engine.sv
// nmix_engine: digit-serial NMIX forward/inverse mixer with chained rounds and valid/ready handshake
module nmix_engine #(
    parameter int WIDTH  = 32,
    parameter int DIGIT  = 1,
    parameter int ROUNDS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] R,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             busy
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int DW = NDIG > 1 ? $clog2(NDIG) : 1;
    localparam int RW = ROUNDS > 1 ? $clog2(ROUNDS) : 1;
    localparam logic [DW-1:0] DLAST = DW'(NDIG - 1);
    localparam logic [RW-1:0] RLAST = RW'(ROUNDS - 1);
    generate
        if (WIDTH % DIGIT != 0 || ROUNDS < 1) begin : g_bad_params
            $error("nmix_engine: WIDTH must be a multiple of DIGIT and ROUNDS >= 1");
        end
    endgenerate
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] xr, rr, xr_n, rr_n;
    logic [DIGIT-1:0] o;
    logic [DW-1:0] dcnt;
    logic [RW-1:0] rcnt;
    logic m, carry, cn;
    // In inverse mode the carry chain must be fed by the recovered x bit, not the register bit
    always_comb begin
        cn = carry;
        o = '0;
        for (int i = 0; i < DIGIT; i++) begin
            o[i] = xr[i] ^ rr[i] ^ cn;
            cn = cn ^ ((m ? o[i] : xr[i]) & rr[i]);
        end
    end
    // Widened concatenations keep the rotate legal when DIGIT == WIDTH
    logic [WIDTH+DIGIT-1:0] xcat, rcat;
    assign xcat = {o, xr};
    assign rcat = {rr[DIGIT-1:0], rr};
    assign xr_n = xcat[WIDTH+DIGIT-1:DIGIT];
    assign rr_n = rcat[WIDTH+DIGIT-1:DIGIT];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            xr        <= '0;
            rr        <= '0;
            m         <= 1'b0;
            carry     <= 1'b0;
            dcnt      <= '0;
            rcnt      <= '0;
            Y         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    xr       <= X;
                    rr       <= R;
                    m        <= mode;
                    carry    <= 1'b0;
                    dcnt     <= '0;
                    rcnt     <= '0;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    state    <= RUN;
                end
                RUN: begin
                    xr <= xr_n;
                    rr <= rr_n;
                    if (dcnt == DLAST) begin
                        carry <= 1'b0;
                        dcnt  <= '0;
                        if (rcnt == RLAST) begin
                            Y         <= xr_n;
                            out_valid <= 1'b1;
                            busy      <= 1'b0;
                            state     <= DONE;
                        end else begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end else begin
                        carry <= cn;
                        dcnt  <= dcnt + 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nmix_engine.sv
// tb_nmix_engine: randomized round-trip and directed checks of nmix_engine in four DIGIT/ROUNDS configurations
module tb_nmix_engine;
    localparam int NC = 4;
    localparam int DG[NC] = '{1, 4, 32, 4};
    localparam int RD[NC] = '{1, 2, 1, 1};
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid[NC], in_ready[NC], mode[NC], out_valid[NC], out_ready[NC], busy[NC];
    logic [31:0] X[NC], R[NC], Y[NC];
    int vectors = 0;
    int errors = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < NC; g++) begin : g_dut
        nmix_engine #(.WIDTH(32), .DIGIT(DG[g]), .ROUNDS(RD[g])) u_dut (
            .clk(clk),
            .reset(reset),
            .in_valid(in_valid[g]),
            .in_ready(in_ready[g]),
            .mode(mode[g]),
            .X(X[g]),
            .R(R[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .Y(Y[g]),
            .busy(busy[g])
        );
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask
    // Forward carries are the prefix XOR of (x & r) shifted up one bit
    function automatic logic [31:0] fwd(input logic [31:0] x, input logic [31:0] r);
        logic [31:0] p;
        p = (x & r) << 1;
        for (int s = 1; s < 32; s *= 2) p ^= p << s;
        return x ^ r ^ p;
    endfunction
    function automatic logic [31:0] inv(input logic [31:0] y, input logic [31:0] r);
        logic [31:0] x;
        logic c;
        x = '0;
        c = 1'b0;
        for (int i = 0; i < 32; i++) begin
            x[i] = y[i] ^ r[i] ^ c;
            c ^= x[i] & r[i];
        end
        return x;
    endfunction
    function automatic logic [31:0] model(input int k, input logic md, input logic [31:0] x, input logic [31:0] r);
        logic [31:0] v;
        v = x;
        for (int n = 0; n < RD[k]; n++) v = md ? inv(v, r) : fwd(v, r);
        return v;
    endfunction
    task automatic run_op(input int k, input logic md, input logic [31:0] x, input logic [31:0] r,
                          input int stall, output logic [31:0] y);
        int n;
        y = '0;
        n = 0;
        while (!in_ready[k] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready[k]) begin
            chk("in_ready_wait", 32'(in_ready[k]), 32'd1);
            return;
        end
        in_valid[k] = 1'b1;
        mode[k] = md;
        X[k] = x;
        R[k] = r;
        @(posedge clk); #1;
        chk("busy_run", 32'(busy[k]), 32'd1);
        chk("in_ready_run", 32'(in_ready[k]), 32'd0);
        n = 0;
        while (!out_valid[k] && n < 400) begin
            X[k] = $urandom;
            R[k] = $urandom;
            mode[k] = ~md;
            out_ready[k] = 1'($urandom_range(0, 1));
            @(posedge clk); #1; n++;
        end
        in_valid[k] = 1'b0;
        out_ready[k] = 1'b0;
        chk("latency", 32'(n), 32'(RD[k] * 32 / DG[k]));
        if (!out_valid[k]) return;
        y = Y[k];
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(out_valid[k]), 32'd1);
            chk("hold_y", Y[k], y);
        end
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        chk("valid_drop", 32'(out_valid[k]), 32'd0);
        chk("in_ready_after", 32'(in_ready[k]), 32'd1);
    endtask
    initial begin
        logic [31:0] x, r, y1, y2;
        logic md;
        for (int k = 0; k < NC; k++) begin
            in_valid[k] = 1'b0;
            mode[k] = 1'b0;
            out_ready[k] = 1'b0;
            X[k] = '0;
            R[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_y", Y[0], 32'h0);
        chk("rst_valid", 32'(out_valid[0]), 32'd0);
        chk("rst_busy", 32'(busy[1]), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready[0]), 32'd1);
        run_op(0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, y1);
        chk("ones_fwd", y1, 32'hAAAAAAAA);
        run_op(0, 1'b0, 32'h00000000, 32'h050D6C7F, 0, y1);
        chk("zero_fwd", y1, 32'h050D6C7F);
        run_op(1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, y1);
        chk("r2_ones_fwd", y1, 32'h99999999);
        for (int k = 0; k < NC; k++) begin
            run_op(k, 1'b0, 32'h8DDC4123, 32'h050D6C7F, 1, y1);
            chk("rt_fwd", y1, model(k, 1'b0, 32'h8DDC4123, 32'h050D6C7F));
            run_op(k, 1'b1, y1, 32'h050D6C7F, 1, y2);
            chk("rt_inv", y2, 32'h8DDC4123);
        end
        // Abandon an operation mid-run: outputs must clear at once, with no result afterwards
        run_op(0, 1'b0, 32'h12345678, 32'h9ABCDEF0, 0, y1);
        in_valid[0] = 1'b1;
        X[0] = 32'hDEADBEEF;
        R[0] = 32'h0BADF00D;
        mode[0] = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid[0]), 32'd0);
        chk("mid_rst_busy", 32'(busy[0]), 32'd0);
        chk("mid_rst_y", Y[0], 32'h0);
        #2;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(in_ready[0]), 32'd1);
        run_op(0, 1'b0, 32'hDEADBEEF, 32'h0BADF00D, 0, y1);
        chk("post_rst_fwd", y1, model(0, 1'b0, 32'hDEADBEEF, 32'h0BADF00D));
        for (int k = 0; k < NC; k++) begin
            for (int n = 0; n < 250; n++) begin
                x = $urandom;
                r = $urandom;
                md = 1'($urandom_range(0, 1));
                run_op(k, md, x, r, $urandom_range(0, 3), y1);
                chk("rand_op", y1, model(k, md, x, r));
                run_op(k, ~md, y1, r, $urandom_range(0, 3), y2);
                chk("rand_back", y2, x);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/nmix_engine.md
Name: nmix_engine

Overview:
- Parametrised, digit-serial successor to the 32-bit nmix mixing primitive used by the ECC/MAC datapath.
- Computes the NMIX forward transform of X keyed by R, or its exact inverse, over WIDTH bits.
- Processes DIGIT bits per cycle and optionally chains ROUNDS iterations.
- Uses a valid/ready handshake on both sides so the MAC and ECC controllers can share one instance.

Parameters:
- WIDTH, 32, operand width in bits.
- DIGIT, 1, bits processed per cycle. WIDTH % DIGIT != 0 is an elaboration error.
- ROUNDS, 1, number of chained NMIX iterations, >= 1. Round k+1 takes the output of round k as X, with the same R.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand request.
- in_ready  out  1  engine can accept an operand (high only in IDLE).
- mode  in  1  0 = forward mix, 1 = inverse (unmix). Sampled at accept.
- X  in  WIDTH  data operand. Sampled at accept.
- R  in  WIDTH  key operand. Sampled at accept.
- out_valid  out  1  Y holds a result.
- out_ready  in  1  consumer takes the result.
- Y  out  WIDTH  result.
- busy  out  1  high in RUN.

Behaviour:
- Reset (reset low, async):
  - state = IDLE; all data registers and counters cleared.
  - Y = 0, out_valid = 0, busy = 0, in_ready = 1 once reset is released.
  - Reset mid-RUN or in DONE abandons the operation; no result is produced.
- Forward transform, bit i from LSB:
  - c_0 = 0; c_i = c_{i-1} ^ (x_{i-1} & r_{i-1}).
  - y_i = x_i ^ r_i ^ c_i.
- Inverse transform:
  - x_i = y_i ^ r_i ^ c_i, where c_i is built from the recovered x bits with the same recurrence.
  - Inverse applied ROUNDS times undoes forward applied ROUNDS times.
- Carry between digits: one carry bit register links consecutive digits. The carry is cleared at the start of every round.
- State machine IDLE -> RUN -> DONE -> IDLE:
  - IDLE: in_ready = 1.
    - Accept when in_valid & in_ready on a rising edge.
    - On accept, latch X, R and mode; clear carry, digit counter and round counter; go to RUN.
  - RUN: each cycle processes the next DIGIT bits, LSB digit first.
    - Data and key registers rotate right by DIGIT; result bits enter the top.
    - After the WIDTH/DIGIT-th digit, the round result becomes the new X, carry clears and the round counter increments.
    - After the last digit of the last round, load Y and go to DONE.
  - DONE: out_valid = 1 and Y is stable.
    - On out_valid & out_ready: go to IDLE, drop out_valid, assert in_ready the next cycle.
    - Y keeps its last value until the next result; it is not cleared.
- Latency: out_valid rises exactly ROUNDS*WIDTH/DIGIT rising edges after the accept edge.
  - Default parameters give 32.
- Throughput: one operation per ROUNDS*WIDTH/DIGIT + 2 cycles. No back-to-back overlap; in_ready is low during RUN and DONE.
- Input/output changes:
  - in_valid, X, R and mode changes during RUN or DONE are ignored.
  - out_ready asserted outside DONE has no effect.
- Counters: the digit counter is ceil(log2(WIDTH/DIGIT)) bits, minimum 1, and wraps to 0 at round end. The round counter saturates at ROUNDS-1.
- DIGIT == WIDTH is legal: one cycle per round.

Test Plan:
- Defaults, X=0xFFFFFFFF, R=0xFFFFFFFF, mode=0 -> Y=0xAAAAAAAA; out_valid rises 32 edges after accept.
- Defaults, X=0x00000000, R=0x050D6C7F, mode=0 -> Y=0x050D6C7F (carry stays 0).
- ROUNDS=2, DIGIT=4, X=R=0xFFFFFFFF, mode=0 -> Y=0x99999999 after 16 edges.
- Round trip at WIDTH=32 with DIGIT in {1, 4, 32}:
  - forward X=0x8DDC4123, R=0x050D6C7F, then feed Y back with mode=1 and the same R -> Y=0x8DDC4123.
  - Repeat with 1000 random pairs and random out_ready stalls; Y must hold while out_ready is low.
- Handshake:
  - in_valid held high with new X during RUN -> ignored.
  - out_ready low for 5 cycles in DONE -> out_valid and Y stay stable.
  - After the out handshake, in_ready = 1 on the next cycle.
- Drop reset low mid-RUN (cycle 10) -> out_valid=0, busy=0, Y=0 immediately. After release, a fresh operation gives the correct result with full latency.
